// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - job sequencer for fill/reuleaux engines with a clipped VGA plot mux
// Optional engine-phase watchdog is enabled by defining DRAW_SEQ_WATCHDOG_EN.
module draw_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
`ifdef DRAW_SEQ_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 20000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_clear,
    input  logic [2:0] req_colour,
    input  logic [7:0] req_centre_x,
    input  logic [6:0] req_centre_y,
    input  logic [7:0] req_diameter,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       fill_start,
    input  logic       fill_done,
    input  logic [7:0] fill_vga_x,
    input  logic [6:0] fill_vga_y,
    input  logic [2:0] fill_vga_colour,
    input  logic       fill_vga_plot,
    output logic       shape_start,
    output logic [2:0] shape_colour,
    output logic [7:0] shape_centre_x,
    output logic [6:0] shape_centre_y,
    output logic [7:0] shape_diameter,
    input  logic       shape_done,
    input  logic [7:0] shape_vga_x,
    input  logic [6:0] shape_vga_y,
    input  logic [2:0] shape_vga_colour,
    input  logic       shape_vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_CLEAR_REL = 3'd2,
        S_DRAW      = 3'd3,
        S_DRAW_REL  = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam logic [8:0] LP_SCREEN_W = 9'(SCREEN_W);
    localparam logic [7:0] LP_SCREEN_H = 8'(SCREEN_H);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_colour;
    logic [7:0] r_centre_x;
    logic [6:0] r_centre_y;
    logic [7:0] r_diameter;

    logic       w_ack;
    logic       w_done;
    logic       w_fill_start;
    logic       w_shape_start;
    logic       w_wdog_hit;
    logic [7:0] w_sel_x;
    logic [6:0] w_sel_y;
    logic [2:0] w_sel_colour;
    logic       w_sel_plot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_colour   <= 3'd0;
            r_centre_x <= 8'd0;
            r_centre_y <= 7'd0;
            r_diameter <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_ack) begin
                r_colour   <= req_colour;
                r_centre_x <= req_centre_x;
                r_centre_y <= req_centre_y;
                r_diameter <= req_diameter;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ack         = 1'b0;
        w_done        = 1'b0;
        w_fill_start  = 1'b0;
        w_shape_start = 1'b0;
        w_sel_x       = 8'd0;
        w_sel_y       = 7'd0;
        w_sel_colour  = 3'd0;
        w_sel_plot    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req && !rst) begin
                    w_ack        = 1'b1;
                    w_state_next = req_clear ? S_CLEAR : S_DRAW;
                end
            end
            S_CLEAR, S_CLEAR_REL: begin
                w_sel_x      = fill_vga_x;
                w_sel_y      = fill_vga_y;
                w_sel_colour = fill_vga_colour;
                w_sel_plot   = fill_vga_plot;
                if (r_state == S_CLEAR) begin
                    w_fill_start = 1'b1;
                    if (fill_done) w_state_next = S_CLEAR_REL;
                end else if (!fill_done) begin
                    w_state_next = S_DRAW;
                end
            end
            S_DRAW, S_DRAW_REL: begin
                w_sel_x      = shape_vga_x;
                w_sel_y      = shape_vga_y;
                w_sel_colour = shape_vga_colour;
                w_sel_plot   = shape_vga_plot;
                if (r_state == S_DRAW) begin
                    w_shape_start = 1'b1;
                    if (shape_done) w_state_next = S_DRAW_REL;
                end else if (!shape_done) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        // A timed-out engine is cut off immediately and the job is closed out normally
        if (w_wdog_hit) begin
            w_fill_start  = 1'b0;
            w_shape_start = 1'b0;
            w_sel_plot    = 1'b0;
            w_state_next  = S_FINISH;
        end
    end

`ifdef DRAW_SEQ_WATCHDOG_EN
    localparam logic [14:0] LP_WDOG = 15'(WDOG_CYCLES);

    logic [14:0] r_wdog_cnt;
    logic        r_err;
    logic        w_phase_active;
    logic        w_phase_entry;

    assign w_phase_active = (r_state == S_CLEAR) || (r_state == S_CLEAR_REL) ||
                            (r_state == S_DRAW)  || (r_state == S_DRAW_REL);
    assign w_phase_entry  = (w_state_next != r_state) &&
                            ((w_state_next == S_CLEAR) || (w_state_next == S_DRAW));
    assign w_wdog_hit     = w_phase_active && (r_wdog_cnt == LP_WDOG);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt <= 15'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_phase_entry) begin
                r_wdog_cnt <= 15'd0;
            end else if (w_phase_active) begin
                r_wdog_cnt <= r_wdog_cnt + 15'd1;
            end
            if (w_ack) begin
                r_err <= 1'b0;
            end else if (w_wdog_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_wdog_hit = 1'b0;
    assign err        = 1'b0;
`endif

    assign ack            = w_ack;
    assign busy           = (r_state != S_IDLE);
    assign done           = w_done;
    assign fill_start     = w_fill_start;
    assign shape_start    = w_shape_start;
    assign shape_colour   = r_colour;
    assign shape_centre_x = r_centre_x;
    assign shape_centre_y = r_centre_y;
    assign shape_diameter = r_diameter;

    assign vga_x      = w_sel_x;
    assign vga_y      = w_sel_y;
    assign vga_colour = w_sel_colour;
    assign vga_plot   = w_sel_plot && ({1'b0, w_sel_x} < LP_SCREEN_W) &&
                        ({1'b0, w_sel_y} < LP_SCREEN_H);

endmodule

// File: tb/tb_draw_sequencer.sv
// tb/tb_draw_sequencer.sv - directed bench for draw_sequencer
module tb_draw_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       req_clear;
    logic [2:0] req_colour;
    logic [7:0] req_centre_x;
    logic [6:0] req_centre_y;
    logic [7:0] req_diameter;
    logic       ack;
    logic       busy;
    logic       done;
    logic       err;
    logic       fill_start;
    logic       fill_done;
    logic [7:0] fill_vga_x;
    logic [6:0] fill_vga_y;
    logic [2:0] fill_vga_colour;
    logic       fill_vga_plot;
    logic       shape_start;
    logic [2:0] shape_colour;
    logic [7:0] shape_centre_x;
    logic [6:0] shape_centre_y;
    logic [7:0] shape_diameter;
    logic       shape_done;
    logic [7:0] shape_vga_x;
    logic [6:0] shape_vga_y;
    logic [2:0] shape_vga_colour;
    logic       shape_vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    always #5 clk = ~clk;

    draw_sequencer #(
        .SCREEN_W(160),
        .SCREEN_H(120)
`ifdef DRAW_SEQ_WATCHDOG_EN
        ,
        .WDOG_CYCLES(50)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_clear(req_clear),
        .req_colour(req_colour), .req_centre_x(req_centre_x),
        .req_centre_y(req_centre_y), .req_diameter(req_diameter),
        .ack(ack), .busy(busy), .done(done), .err(err),
        .fill_start(fill_start), .fill_done(fill_done),
        .fill_vga_x(fill_vga_x), .fill_vga_y(fill_vga_y),
        .fill_vga_colour(fill_vga_colour), .fill_vga_plot(fill_vga_plot),
        .shape_start(shape_start), .shape_colour(shape_colour),
        .shape_centre_x(shape_centre_x), .shape_centre_y(shape_centre_y),
        .shape_diameter(shape_diameter), .shape_done(shape_done),
        .shape_vga_x(shape_vga_x), .shape_vga_y(shape_vga_y),
        .shape_vga_colour(shape_vga_colour), .shape_vga_plot(shape_vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    typedef struct {
        logic       src_shape;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
        logic       exp_plot;
    } vec_t;

    vec_t tbl[10];
    int   total = 0;
    int   bad = 0;
    int   overlap = 0;
    int   done_pulses = 0;

    always @(negedge clk) begin
        if (fill_start && shape_start) overlap++;
        if (done) done_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vectors(input logic want_shape);
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].src_shape == want_shape) begin
                if (want_shape) begin
                    shape_vga_x = tbl[i].x; shape_vga_y = tbl[i].y;
                    shape_vga_colour = tbl[i].c; shape_vga_plot = tbl[i].p;
                end else begin
                    fill_vga_x = tbl[i].x; fill_vga_y = tbl[i].y;
                    fill_vga_colour = tbl[i].c; fill_vga_plot = tbl[i].p;
                end
                #1;
                check($sformatf("vec%0d_x", i), vga_x, tbl[i].x);
                check($sformatf("vec%0d_y", i), vga_y, tbl[i].y);
                check($sformatf("vec%0d_colour", i), vga_colour, tbl[i].c);
                check($sformatf("vec%0d_plot", i), vga_plot, tbl[i].exp_plot);
            end
        end
    endtask

    initial begin
        int drops;
        tbl[0] = '{1'b0, 8'd0,   7'd0,   3'd1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 8'd159, 7'd119, 3'd7, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 8'd160, 7'd0,   3'd2, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'd20,  7'd30,  3'd4, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'd159, 7'd119, 3'd3, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 8'd160, 7'd50,  3'd3, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 8'd10,  7'd120, 3'd3, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 8'd255, 7'd127, 3'd3, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 8'd5,   7'd6,   3'd2, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 8'd0,   7'd119, 3'd1, 1'b0, 1'b0};

        rst = 1'b1; req = 1'b1; req_clear = 1'b0;
        req_colour = 3'd0; req_centre_x = 8'd0; req_centre_y = 7'd0; req_diameter = 8'd0;
        fill_done = 1'b0; fill_vga_x = 8'd0; fill_vga_y = 7'd0;
        fill_vga_colour = 3'd0; fill_vga_plot = 1'b0;
        shape_done = 1'b0; shape_vga_x = 8'd7; shape_vga_y = 7'd7;
        shape_vga_colour = 3'd7; shape_vga_plot = 1'b1;
        tick(); tick();

        // reset state, with req held to show ack is suppressed
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_fill_start", fill_start, 0);
        check("rst_shape_start", shape_start, 0);
        check("rst_centre_x", shape_centre_x, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_plot", vga_plot, 0);
        req = 1'b0; rst = 1'b0;
        tick();
        check("idle_vga_plot", vga_plot, 0);

        // no-clear job
        req = 1'b1; req_clear = 1'b0; req_colour = 3'b010;
        req_centre_x = 8'd40; req_centre_y = 7'd80; req_diameter = 8'd3;
        #1;
        check("j1_ack", ack, 1);
        tick();
        req = 1'b0;
        check("j1_ack_pulse", ack, 0);
        check("j1_busy", busy, 1);
        check("j1_shape_start", shape_start, 1);
        check("j1_fill_start", fill_start, 0);
        check("j1_centre_x", shape_centre_x, 40);
        check("j1_centre_y", shape_centre_y, 80);
        check("j1_diameter", shape_diameter, 3);
        check("j1_colour", shape_colour, 3'b010);
        shape_vga_x = 8'd12; shape_vga_y = 7'd34; shape_vga_colour = 3'd5; shape_vga_plot = 1'b1;
        #1;
        check("j1_vga_x", vga_x, 12);
        check("j1_vga_y", vga_y, 34);
        check("j1_vga_colour", vga_colour, 5);
        check("j1_vga_plot", vga_plot, 1);

        // second request while busy
        req = 1'b1; req_centre_x = 8'd10; req_centre_y = 7'd10;
        #1;
        check("busy_no_ack", ack, 0);
        tick();
        check("busy_centre_x", shape_centre_x, 40);
        check("busy_centre_y", shape_centre_y, 80);
        drops = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (!shape_start || ack) drops++;
        end
        check("j1_start_held", drops, 0);
        shape_done = 1'b1;
        tick();
        check("j1_rel_shape_start", shape_start, 0);
        check("j1_rel_vga_x", vga_x, 12);
        shape_done = 1'b0;
        tick();
        check("j1_done", done, 1);
        check("j1_done_busy", busy, 1);
        check("j1_done_no_ack", ack, 0);
        check("j1_finish_plot", vga_plot, 0);
        tick();
        check("j1_done_pulse", done, 0);
        check("j1_idle_busy", busy, 0);
        check("held_req_ack", ack, 1);
        check("j1_done_count", done_pulses, 1);

        // held request becomes a minimum-length job
        tick();
        req = 1'b0;
        check("j2_centre_x", shape_centre_x, 10);
        check("j2_centre_y", shape_centre_y, 10);
        shape_done = 1'b1;
        tick();
        shape_done = 1'b0;
        tick();
        check("j2_min_done", done, 1);
        tick();

        // clear then draw
        req = 1'b1; req_clear = 1'b1; req_colour = 3'b110;
        req_centre_x = 8'd80; req_centre_y = 7'd60; req_diameter = 8'd20;
        #1;
        check("j3_ack", ack, 1);
        tick();
        req = 1'b0;
        check("j3_fill_start", fill_start, 1);
        check("j3_shape_start", shape_start, 0);
        shape_vga_x = 8'd1; shape_vga_y = 7'd2; shape_vga_colour = 3'd3; shape_vga_plot = 1'b1;
        apply_vectors(1'b0);
        drops = 0;
        for (int i = 0; i < 19200; i++) begin
            tick();
            if (!fill_start || shape_start) drops++;
        end
        check("j3_fill_held", drops, 0);
        fill_done = 1'b1;
        fill_vga_x = 8'd100; fill_vga_y = 7'd50; fill_vga_colour = 3'd4; fill_vga_plot = 1'b1;
        tick();
        check("j3_rel_fill_start", fill_start, 0);
        check("j3_rel_shape_start", shape_start, 0);
        check("j3_rel_vga_x", vga_x, 100);
        check("j3_rel_vga_plot", vga_plot, 1);
        tick();
        check("j3_rel_wait", shape_start, 0);
        fill_done = 1'b0;
        tick();
        check("j3_draw_start", shape_start, 1);
        check("j3_draw_vga_x", vga_x, 1);
        check("j3_draw_fill_start", fill_start, 0);
        apply_vectors(1'b1);
        shape_done = 1'b1;
        tick();
        shape_done = 1'b0;
        tick();
        check("j3_done", done, 1);
        tick();
        check("overlap", overlap, 0);
        check("done_count", done_pulses, 3);

`ifdef DRAW_SEQ_WATCHDOG_EN
        req = 1'b1; req_clear = 1'b0;
        tick();
        req = 1'b0;
        drops = 0;
        for (int i = 0; i < 200 && shape_start; i++) begin
            drops++;
            tick();
        end
        check("wdog_cycles", drops, 50);
        check("wdog_plot", vga_plot, 0);
        tick();
        check("wdog_done", done, 1);
        check("wdog_err", err, 1);
        tick();
        check("wdog_err_sticky", err, 1);
        req = 1'b1;
        #1;
        check("wdog_next_ack", ack, 1);
        tick();
        req = 1'b0;
        check("wdog_err_clear", err, 0);
        shape_done = 1'b1;
        tick();
        shape_done = 1'b0;
        tick(); tick();
`endif

        // reset in the middle of a draw
        req = 1'b1; req_clear = 1'b0;
        tick();
        req = 1'b0;
        shape_vga_x = 8'd5; shape_vga_y = 7'd5; shape_vga_colour = 3'd1; shape_vga_plot = 1'b1;
        #1;
        check("mid_shape_start", shape_start, 1);
        check("mid_vga_plot", vga_plot, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_shape_start", shape_start, 0);
        check("mid_rst_vga_plot", vga_plot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_centre_x", shape_centre_x, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
